jtframe_shram_arb: RTL and testbench

Two-requester arbiter for one single-port synchronous shared RAM, typically two Z80s (main/sound) exchanging data.
- Per-requester busy outputs feed the dev_busy inputs of each CPU's jtframe_z80wait, so a CPU's clock enable is gated until its access completes.
- Grants one access at a time, round-robin on ties, and holds read data per requester until that CPU samples it.

---
 rtl/jtframe_shram_pkg.sv | 13 +
 rtl/jtframe_shram_port.sv | 49 ++++
 rtl/jtframe_shram_arb.sv | 124 ++++++++++++
 tb/tb_jtframe_shram_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_shram_pkg.sv
// Shared definitions for the two-requester shared RAM arbiter.
// Holds the FSM state encoding and the legal read-latency range.
package jtframe_shram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 3;

endpackage

// File: rtl/jtframe_shram_port.sv
// Per-requester tracker: remembers which address was last served while the
// chip select stays high, raises pending for new work and holds read data.
module jtframe_shram_port
  import jtframe_shram_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          cmpl_i,
  input  logic          rd_i,
  input  logic [AW-1:0] ram_addr_i,
  input  logic [DW-1:0] ram_dout_i,
  output logic          pending_o,
  output logic [DW-1:0] dout_o
);

  logic          done_q, done_d;
  logic [AW-1:0] served_q;
  logic [DW-1:0] dout_q;

  // A dropped chip select always forgets the finished access, even on completion
  always_comb begin
    done_d = done_q;
    if (!cs_i)       done_d = 1'b0;
    else if (cmpl_i) done_d = 1'b1;
  end

  assign pending_o = cs_i & (~done_q | (addr_i != served_q));
  assign dout_o    = dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      served_q <= '0;
      dout_q   <= '0;
    end else begin
      done_q <= done_d;
      if (cmpl_i) begin
        served_q <= ram_addr_i;
        if (rd_i) dout_q <= ram_dout_i;
      end
    end
  end

endmodule

// File: rtl/jtframe_shram_arb.sv
// Round-robin arbiter giving two CPUs access to one single-port synchronous RAM;
// busy stalls each CPU through its wait block until its own access completes.
module jtframe_shram_arb
  import jtframe_shram_pkg::*;
#(
  parameter int AW  = 11,
  parameter int DW  = 8,
  parameter int LAT = 1
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic [1:0]      req_cs,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_din,
  output logic [2*DW-1:0] req_dout,
  output logic [1:0]      busy,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_we,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_range
    $error("jtframe_shram_arb: LAT out of range");
  end

  localparam logic [1:0] LAT_CNT = 2'(LAT);

  state_e        state_q;
  logic          last_q, g_q, wr_q, gnt_d;
  logic [1:0]    cnt_q;
  logic [AW-1:0] ram_addr_q;
  logic          ram_we_q;
  logic [DW-1:0] ram_din_q;
  logic [1:0]    pending, cmpl;
  logic          complete;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;

  assign complete = (state_q == ACCESS) && (cnt_q == LAT_CNT);
  assign cmpl[0]  = complete & ~g_q;
  assign cmpl[1]  = complete &  g_q;
  assign busy     = pending;
  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;
  assign ram_din  = ram_din_q;

  // Ties go to whoever was not served last
  always_comb begin
    gnt_d = 1'b0;
    case (pending)
      2'b10:   gnt_d = 1'b1;
      2'b11:   gnt_d = ~last_q;
      default: gnt_d = 1'b0;
    endcase
    sel_addr = gnt_d ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    sel_din  = gnt_d ? req_din[2*DW-1:DW]  : req_din[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      g_q        <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ram_we_q <= 1'b0;
          if (|pending) begin
            g_q        <= gnt_d;
            wr_q       <= req_we[gnt_d];
            ram_we_q   <= req_we[gnt_d];
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
            cnt_q      <= 2'd0;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we_q <= 1'b0;
          cnt_q    <= cnt_q + 2'd1;
          if (complete) begin
            last_q  <= g_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  jtframe_shram_port #(.AW(AW), .DW(DW)) u_port0 (
    .rst_n      (rst_n),
    .clk        (clk),
    .cs_i       (req_cs[0]),
    .addr_i     (req_addr[AW-1:0]),
    .cmpl_i     (cmpl[0]),
    .rd_i       (~wr_q),
    .ram_addr_i (ram_addr_q),
    .ram_dout_i (ram_dout),
    .pending_o  (pending[0]),
    .dout_o     (req_dout[DW-1:0])
  );

  jtframe_shram_port #(.AW(AW), .DW(DW)) u_port1 (
    .rst_n      (rst_n),
    .clk        (clk),
    .cs_i       (req_cs[1]),
    .addr_i     (req_addr[2*AW-1:AW]),
    .cmpl_i     (cmpl[1]),
    .rd_i       (~wr_q),
    .ram_addr_i (ram_addr_q),
    .ram_dout_i (ram_dout),
    .pending_o  (pending[1]),
    .dout_o     (req_dout[2*DW-1:DW])
  );

endmodule

// File: tb/tb_jtframe_shram_arb.sv
// Directed bench for jtframe_shram_arb with a one-cycle-latency RAM model.
module tb_jtframe_shram_arb;

  logic        rst_n, clk;
  logic [1:0]  cs, we;
  logic [10:0] a0, a1;
  logic [7:0]  d0, d1;
  logic [21:0] req_addr;
  logic [15:0] req_din, req_dout;
  logic [1:0]  busy;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din, ram_dout;
  logic [7:0]  mem [2048];

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  logic [10:0] we_addr = '0;
  logic [7:0]  we_din = '0;

  assign req_addr = {a1, a0};
  assign req_din  = {d1, d0};

  jtframe_shram_arb #(.AW(11), .DW(8), .LAT(1)) dut (
    .rst_n    (rst_n),
    .clk      (clk),
    .req_cs   (cs),
    .req_we   (we),
    .req_addr (req_addr),
    .req_din  (req_din),
    .req_dout (req_dout),
    .busy     (busy),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; contents preloaded while reset is held
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[11'h000] <= 8'h21;
      mem[11'h001] <= 8'h42;
      mem[11'h010] <= 8'h5A;
      mem[11'h123] <= 8'h96;
      mem[11'h7FF] <= 8'h3C;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = ram_addr;
      we_din  = ram_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic count_busy(input int i, output int n);
    n = 0;
    #1;
    while (busy[i] && n < 20) begin
      n++;
      @(posedge clk);
      #2;
    end
  endtask

  int n, w0;

  initial begin
    rst_n = 1'b0; cs = 2'b00; we = 2'b00;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    cyc();
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_we",   32'(ram_we),   32'h0);
    check("rst_ram_din",  32'(ram_din),  32'h0);
    check("rst_req_dout", 32'(req_dout), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    cs = 2'b01; #1;
    check("rst_busy_comb", 32'(busy), 32'h1);
    cs = 2'b00;
    cyc(); rst_n = 1'b1; cyc();

    // Single read by requester 0
    w0 = we_cnt;
    a0 = 11'h010; cs = 2'b01;
    count_busy(0, n);
    check("t1_busy_len", 32'(n), 32'd3);
    check("t1_dout0", 32'(req_dout[7:0]), 32'h5A);
    check("t1_no_we", 32'(we_cnt - w0), 32'd0);
    cs = 2'b00; cyc();

    // Collision right after reset: requester 0 first
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    a0 = 11'h010; a1 = 11'h123; cs = 2'b11;
    count_busy(0, n);
    check("t2_busy0_len", 32'(n), 32'd3);
    check("t2_dout0", 32'(req_dout[7:0]), 32'h5A);
    count_busy(1, n);
    check("t2_busy1_extra", 32'(n), 32'd3);
    check("t2_dout1", 32'(req_dout[15:8]), 32'h96);
    cs = 2'b00; cyc();
    a0 = 11'h7FF; cs = 2'b01;
    count_busy(0, n);
    check("t2_solo_len", 32'(n), 32'd3);
    check("t2_solo_dout0", 32'(req_dout[7:0]), 32'h3C);
    cs = 2'b00; cyc();
    a0 = 11'h010; a1 = 11'h123; cs = 2'b11;
    count_busy(1, n);
    check("t2_rr_busy1_len", 32'(n), 32'd3);
    count_busy(0, n);
    check("t2_rr_busy0_extra", 32'(n), 32'd3);
    check("t2_rr_dout0", 32'(req_dout[7:0]), 32'h5A);
    cs = 2'b00; cyc();

    // Requester 1 writes
    w0 = we_cnt;
    a1 = 11'h7FF; d1 = 8'hC3; we = 2'b10; cs = 2'b10;
    count_busy(1, n);
    check("t3_busy_len", 32'(n), 32'd3);
    check("t3_dout1_kept", 32'(req_dout[15:8]), 32'h96);
    check("t3_we_pulses", 32'(we_cnt - w0), 32'd1);
    check("t3_we_addr", 32'(we_addr), 32'h7FF);
    check("t3_we_din", 32'(we_din), 32'hC3);
    cs = 2'b00; we = 2'b00; cyc();
    a0 = 11'h7FF; cs = 2'b01;
    count_busy(0, n);
    check("t3_readback_len", 32'(n), 32'd3);
    check("t3_readback", 32'(req_dout[7:0]), 32'hC3);
    cs = 2'b00; cyc();

    // Back-to-back accesses with cs held
    a0 = 11'h000; cs = 2'b01;
    count_busy(0, n);
    check("t4_first_len", 32'(n), 32'd3);
    check("t4_first_dout", 32'(req_dout[7:0]), 32'h21);
    cyc();
    check("t4_held_idle", 32'(busy[0]), 32'h0);
    a0 = 11'h001; #1;
    check("t4_rebusy", 32'(busy[0]), 32'h1);
    count_busy(0, n);
    check("t4_second_len", 32'(n), 32'd3);
    check("t4_second_dout", 32'(req_dout[7:0]), 32'h42);
    cs = 2'b00; cyc();

    // Chip select dropped during a write
    w0 = we_cnt;
    a0 = 11'h020; d0 = 8'h11; we = 2'b01; cs = 2'b01;
    cyc();
    cs = 2'b00; we = 2'b00; #1;
    check("t5_busy_drop", 32'(busy), 32'h0);
    cyc(); cyc();
    check("t5_busy_after", 32'(busy), 32'h0);
    check("t5_we_pulses", 32'(we_cnt - w0), 32'd1);
    check("t5_we_addr", 32'(we_addr), 32'h020);
    check("t5_dout0_kept", 32'(req_dout[7:0]), 32'h42);
    a1 = 11'h020; cs = 2'b10;
    count_busy(1, n);
    check("t5_read_len", 32'(n), 32'd3);
    check("t5_readback", 32'(req_dout[15:8]), 32'h11);
    cs = 2'b00; cyc();

    // Reset in the middle of an access
    a0 = 11'h010; cs = 2'b01;
    cyc(); cyc();
    rst_n = 1'b0; #1;
    check("t6_ram_we", 32'(ram_we), 32'h0);
    check("t6_req_dout", 32'(req_dout), 32'h0);
    check("t6_ram_addr", 32'(ram_addr), 32'h0);
    check("t6_busy", 32'(busy), 32'h1);
    cyc();
    rst_n = 1'b1;
    count_busy(0, n);
    check("t6_restart_len", 32'(n), 32'd3);
    check("t6_restart_dout", 32'(req_dout[7:0]), 32'h5A);
    cs = 2'b00; cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
